// File: rtl/l1_icache_nway_pkg.sv
// mem_pkg: shared types for the L1 instruction cache.
//   cache_entry_t : one line (valid, tag, data) for the default geometry
//   state_e       : cache controller states
//   age_w()       : width of a per-way LRU age for a given associativity
package mem_pkg;

  localparam int unsigned DEF_WAYS        = 4;
  localparam int unsigned DEF_SETS        = 8;
  localparam int unsigned DEF_BLOCK_WORDS = 4;
  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_OFF_W       = $clog2(DEF_BLOCK_WORDS) + 2;
  localparam int unsigned DEF_SET_W       = $clog2(DEF_SETS);
  localparam int unsigned DEF_TAG_W       = DEF_ADDR_W - DEF_SET_W - DEF_OFF_W;
  localparam int unsigned DEF_LINE_W      = 32 * DEF_BLOCK_WORDS;

  typedef struct packed {
    logic                  valid;
    logic [DEF_TAG_W-1:0]  tag;
    logic [DEF_LINE_W-1:0] data;
  } cache_entry_t;

  typedef enum logic [1:0] {
    LOOKUP,
    WB_WAIT,
    REFILL,
    FLUSH
  } state_e;

  function automatic int unsigned age_w(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/l1_icache_nway_lru_ages.sv
// lru_ages: true-LRU age array, one age per way per set (0 = MRU).
//   clk_i, rst_ni : clock, async active-low reset (way w resets to age w)
//   promote_i     : make way_i the MRU of set_i at the clock edge
//   set_i, way_i  : set being accessed / way being promoted
//   victim_o      : oldest way of set_i
module lru_ages
  import mem_pkg::*;
#(
  parameter  int unsigned WAYS  = 4,
  parameter  int unsigned SETS  = 8,
  localparam int unsigned WAY_W = age_w(WAYS),
  localparam int unsigned SET_W = $clog2(SETS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             promote_i,
  input  logic [SET_W-1:0] set_i,
  input  logic [WAY_W-1:0] way_i,
  output logic [WAY_W-1:0] victim_o
);

  logic [WAY_W-1:0] age_q [SETS][WAYS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          age_q[s][w] <= WAY_W'(w);
        end
      end
    end else if (promote_i) begin
      // Only ways younger than the promoted one age, so the set stays a permutation.
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == way_i) begin
          age_q[set_i][w] <= '0;
        end else if (age_q[set_i][w] < age_q[set_i][way_i]) begin
          age_q[set_i][w] <= age_q[set_i][w] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    victim_o = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (age_q[set_i][w] == WAY_W'(WAYS - 1)) victim_o = WAY_W'(w);
    end
  end

endmodule

// File: rtl/l1_icache_nway.sv
// l1_icache_nway: N-way set-associative L1 instruction cache, true LRU,
// data-cache write-back handshake before refill, coherence invalidates and
// a one-set-per-cycle flush engine.
//   clk_i, rst_ni                 : clock, async active-low reset
//   cpu_valid_i/addr_i            : fetch request (address held until ready)
//   cpu_ready_o/rdata_o           : combinational hit response
//   inv_valid_i/addr_i            : invalidate request from the data cache
//   flush_i / flush_busy_o        : whole-cache invalidate and its busy flag
//   wb_req_o/addr_o, wb_done_i    : write-back request to the data cache
//   mem_valid_o/addr_o, mem_ready_i/rdata_i : line refill from memory
module l1_icache_nway
  import mem_pkg::*;
#(
  parameter  int unsigned WAYS        = 4,
  parameter  int unsigned SETS        = 8,
  parameter  int unsigned BLOCK_WORDS = 4,
  parameter  int unsigned ADDR_W      = 32,
  localparam int unsigned OFF_W       = $clog2(BLOCK_WORDS) + 2,
  localparam int unsigned SET_W       = $clog2(SETS),
  localparam int unsigned TAG_W       = ADDR_W - SET_W - OFF_W,
  localparam int unsigned LINE_W      = 32 * BLOCK_WORDS
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_valid_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic              cpu_ready_o,
  output logic [31:0]       cpu_rdata_o,
  input  logic              inv_valid_i,
  input  logic [ADDR_W-1:0] inv_addr_i,
  input  logic              flush_i,
  output logic              flush_busy_o,
  output logic              wb_req_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  input  logic              wb_done_i,
  output logic              mem_valid_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ready_i,
  input  logic [LINE_W-1:0] mem_rdata_i
);

  localparam int unsigned WAY_W  = age_w(WAYS);
  localparam int unsigned WORD_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  state_e state_q, state_d;

  logic [SETS-1:0]   valid_q [WAYS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [LINE_W-1:0] data_q  [WAYS][SETS];

  logic [SET_W-1:0]  fl_cnt_q;
  logic [WAY_W-1:0]  victim_q, victim_sel, lru_victim, hit_way, promote_way;
  logic [WAYS-1:0]   hit, inv_hit;
  logic              hit_any, any_invalid, lookup_hit, refill_fire, refill_inv, promote;

  logic [TAG_W-1:0]  cpu_tag, inv_tag;
  logic [SET_W-1:0]  cpu_set, inv_set;
  logic [WORD_W-1:0] cpu_word;
  logic [ADDR_W-1:0] line_addr;
  logic              unused_addr_bits;

  assign cpu_tag   = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign cpu_set   = cpu_addr_i[OFF_W +: SET_W];
  // With single-word lines bit 2 belongs to the set field, so mask it out.
  assign cpu_word  = cpu_addr_i[2 +: WORD_W] & WORD_W'(BLOCK_WORDS - 1);
  assign inv_tag   = inv_addr_i[ADDR_W-1 -: TAG_W];
  assign inv_set   = inv_addr_i[OFF_W +: SET_W];
  assign line_addr = {cpu_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign unused_addr_bits = ^{cpu_addr_i[1:0], inv_addr_i[OFF_W-1:0]};

  always_comb begin
    hit         = '0;
    inv_hit     = '0;
    hit_way     = '0;
    victim_sel  = lru_victim;
    any_invalid = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      hit[w]     = valid_q[w][cpu_set] && (tag_q[w][cpu_set] == cpu_tag);
      inv_hit[w] = inv_valid_i && valid_q[w][inv_set] && (tag_q[w][inv_set] == inv_tag);
      if (hit[w]) hit_way = WAY_W'(w);
      if (!valid_q[w][cpu_set] && !any_invalid) begin
        any_invalid = 1'b1;
        victim_sel  = WAY_W'(w);
      end
    end
  end

  assign hit_any     = |hit;
  assign lookup_hit  = (state_q == LOOKUP) && cpu_valid_i && hit_any;
  assign refill_fire = (state_q == REFILL) && mem_ready_i;
  assign refill_inv  = inv_valid_i && (inv_set == cpu_set) && (inv_tag == cpu_tag);
  assign promote     = lookup_hit || refill_fire;
  assign promote_way = refill_fire ? victim_q : hit_way;

  lru_ages #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .promote_i (promote),
    .set_i     (cpu_set),
    .way_i     (promote_way),
    .victim_o  (lru_victim)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOOKUP: begin
        if (flush_i)                       state_d = FLUSH;
        else if (cpu_valid_i && !hit_any)  state_d = WB_WAIT;
      end
      WB_WAIT: if (wb_done_i)              state_d = REFILL;
      REFILL:  if (mem_ready_i)            state_d = LOOKUP;
      FLUSH:   if (fl_cnt_q == SET_W'(SETS - 1)) state_d = LOOKUP;
      default:                             state_d = LOOKUP;
    endcase
  end

  always_comb begin
    cpu_ready_o  = lookup_hit;
    cpu_rdata_o  = lookup_hit ? data_q[hit_way][cpu_set][cpu_word*32 +: 32] : '0;
    wb_req_o     = (state_q == WB_WAIT);
    wb_addr_o    = wb_req_o ? line_addr : '0;
    mem_valid_o  = (state_q == REFILL);
    mem_addr_o   = mem_valid_o ? line_addr : '0;
    flush_busy_o = (state_q == FLUSH);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= LOOKUP;
      fl_cnt_q <= '0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      fl_cnt_q <= (state_q == FLUSH && fl_cnt_q != SET_W'(SETS - 1)) ? fl_cnt_q + 1'b1 : '0;
      if (state_q == WB_WAIT && wb_done_i) victim_q <= victim_sel;
    end
  end

  // Later assignments win: an invalidate overrides both flush and refill writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned w = 0; w < WAYS; w++) valid_q[w] <= '0;
    end else begin
      if (state_q == FLUSH) begin
        for (int unsigned w = 0; w < WAYS; w++) valid_q[w][fl_cnt_q] <= 1'b0;
      end
      if (refill_fire) valid_q[victim_q][cpu_set] <= !refill_inv;
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (inv_hit[w]) valid_q[w][inv_set] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (refill_fire) begin
      tag_q[victim_q][cpu_set]  <= cpu_tag;
      data_q[victim_q][cpu_set] <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_l1_icache_nway.sv
// Directed bench for l1_icache_nway (WAYS=4, SETS=8, BLOCK_WORDS=4).
// Expected fetch words are queued when a fetch is issued and popped when
// the cache responds; each word is a fixed function of its address.
module tb_l1_icache_nway;

  localparam int unsigned LINE_W = 128;

  logic              clk, rst_n;
  logic              cpu_valid, cpu_ready;
  logic [31:0]       cpu_addr, cpu_rdata;
  logic              inv_valid, flush, flush_busy;
  logic [31:0]       inv_addr;
  logic              wb_req, wb_done, mem_valid, mem_ready;
  logic [31:0]       wb_addr, mem_addr;
  logic [LINE_W-1:0] mem_rdata;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_q [$];

  l1_icache_nway #(
    .WAYS        (4),
    .SETS        (8),
    .BLOCK_WORDS (4),
    .ADDR_W      (32)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cpu_valid_i  (cpu_valid),
    .cpu_addr_i   (cpu_addr),
    .cpu_ready_o  (cpu_ready),
    .cpu_rdata_o  (cpu_rdata),
    .inv_valid_i  (inv_valid),
    .inv_addr_i   (inv_addr),
    .flush_i      (flush),
    .flush_busy_o (flush_busy),
    .wb_req_o     (wb_req),
    .wb_addr_o    (wb_addr),
    .wb_done_i    (wb_done),
    .mem_valid_o  (mem_valid),
    .mem_addr_o   (mem_addr),
    .mem_ready_i  (mem_ready),
    .mem_rdata_i  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [LINE_W-1:0] model_line(input logic [31:0] a);
    logic [LINE_W-1:0] l;
    logic [31:0] base;
    base = {a[31:4], 4'h0};
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = model_word(base + 32'(4 * i));
    return l;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered at negedge+1 with the cache in WB_WAIT; leaves mem_ready high.
  task automatic serve(input logic [31:0] a, input int wb_lat, input int mem_lat);
    chk("wb_req", {31'd0, wb_req}, 32'd1);
    chk("wb_addr", wb_addr, {a[31:4], 4'h0});
    for (int i = 0; i < wb_lat; i++) begin
      @(negedge clk); #1;
      chk("wb_hold", {wb_req, wb_addr[30:0]}, {1'b1, 27'd0, a[30:4], 4'h0} | 32'h8000_0000);
    end
    wb_done = 1'b1;
    @(negedge clk); wb_done = 1'b0; #1;
    chk("mem_valid", {30'd0, wb_req, mem_valid}, 32'd1);
    chk("mem_addr", mem_addr, {a[31:4], 4'h0});
    for (int i = 0; i < mem_lat; i++) begin
      @(negedge clk); #1;
      chk("mem_hold", mem_addr, {a[31:4], 4'h0});
    end
    mem_rdata = model_line(a);
    mem_ready = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] a, input bit exp_hit);
    int n;
    exp_q.push_back(model_word(a));
    @(negedge clk);
    cpu_valid = 1'b1;
    cpu_addr  = a;
    #1;
    chk($sformatf("hit_now_%h", a), {31'd0, cpu_ready}, {31'd0, exp_hit});
    if (!exp_hit) begin
      @(negedge clk); #1;
      serve(a, 1, 2);
      @(negedge clk); mem_ready = 1'b0; #1;
    end
    n = 0;
    while (!cpu_ready && n < 8) begin
      @(negedge clk); #1; n++;
    end
    chk($sformatf("ready_%h", a), {31'd0, cpu_ready}, 32'd1);
    chk($sformatf("rdata_%h", a), cpu_rdata, exp_q.pop_front());
  endtask

  initial begin
    int busy_cnt;
    logic [31:0] a;
    rst_n = 1'b0; cpu_valid = 1'b0; cpu_addr = '0; inv_valid = 1'b0; inv_addr = '0;
    flush = 1'b0; wb_done = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outs", {28'd0, cpu_ready, wb_req, mem_valid, flush_busy}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_wb_addr", wb_addr, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Cold miss then same-line hit.
    fetch(32'h0000_0040, 1'b0);
    fetch(32'h0000_004C, 1'b1);

    // LRU in set 0: fill T0..T3, touch T0, T4 must evict T1.
    fetch(32'h0000_1000, 1'b0);
    fetch(32'h0000_2000, 1'b0);
    fetch(32'h0000_3000, 1'b0);
    fetch(32'h0000_4000, 1'b0);
    fetch(32'h0000_1004, 1'b1);
    fetch(32'h0000_5000, 1'b0);
    fetch(32'h0000_1008, 1'b1);
    fetch(32'h0000_3000, 1'b1);
    fetch(32'h0000_4000, 1'b1);
    fetch(32'h0000_5004, 1'b1);
    fetch(32'h0000_2000, 1'b0);

    // Non-resident invalidate changes nothing.
    @(negedge clk); cpu_valid = 1'b0; inv_valid = 1'b1; inv_addr = 32'h0000_9040;
    @(negedge clk); inv_valid = 1'b0;
    fetch(32'h0000_0044, 1'b1);
    // Invalidate in the same cycle as a hit: old data still returned.
    @(negedge clk); cpu_addr = 32'h0000_004C; inv_valid = 1'b1; inv_addr = 32'h0000_0040; #1;
    chk("inv_same_cycle_ready", {31'd0, cpu_ready}, 32'd1);
    chk("inv_same_cycle_data", cpu_rdata, model_word(32'h0000_004C));
    @(negedge clk); cpu_valid = 1'b0; inv_valid = 1'b0;
    fetch(32'h0000_0048, 1'b0);

    // Invalidate colliding with the refill beat.
    a = 32'h0002_0000;
    exp_q.push_back(model_word(a));
    @(negedge clk); cpu_valid = 1'b1; cpu_addr = a; #1;
    chk("coll_miss", {31'd0, cpu_ready}, 32'd0);
    @(negedge clk); #1; wb_done = 1'b1;
    @(negedge clk); wb_done = 1'b0; #1;
    chk("coll_refill", {31'd0, mem_valid}, 32'd1);
    mem_rdata = model_line(a); mem_ready = 1'b1; inv_valid = 1'b1; inv_addr = a;
    @(negedge clk); mem_ready = 1'b0; inv_valid = 1'b0; #1;
    chk("coll_lookup_miss", {29'd0, cpu_ready, wb_req, mem_valid}, 32'd0);
    @(negedge clk); #1;
    chk("coll_rewb", {31'd0, wb_req}, 32'd1);
    serve(a, 0, 0);
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("coll_ready", {31'd0, cpu_ready}, 32'd1);
    chk("coll_rdata", cpu_rdata, exp_q.pop_front());

    // Flush: exactly 8 busy cycles; a second flush pulse during busy is ignored.
    @(negedge clk); cpu_valid = 1'b0; flush = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      flush = (i == 2);
      #1;
      if (flush_busy) begin
        busy_cnt++;
        chk("flush_quiet", {30'd0, wb_req, mem_valid}, 32'd0);
      end
    end
    chk("flush_cycles", busy_cnt, 32'd8);
    fetch(32'h0000_0044, 1'b0);
    fetch(32'h0000_3000, 1'b0);

    // Asynchronous reset while in REFILL.
    @(negedge clk); cpu_addr = 32'h0000_0080; #1;
    chk("rst_test_miss", {31'd0, cpu_ready}, 32'd0);
    @(negedge clk); #1; wb_done = 1'b1;
    @(negedge clk); wb_done = 1'b0; #1;
    chk("rst_test_refill", {31'd0, mem_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_mem_valid_drop", {31'd0, mem_valid}, 32'd0);
    chk("async_mem_addr_zero", mem_addr, 32'd0);
    @(negedge clk); cpu_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    fetch(32'h0000_0044, 1'b0);
    fetch(32'h0000_3000, 1'b0);

    @(negedge clk); cpu_valid = 1'b0;
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/l1_icache_nway.md
# l1_icache_nway

Parametrised N-way set-associative L1 instruction cache with true-LRU replacement, asynchronous reset and a bulk flush engine. It sits between the fetch stage and main memory. Before any refill it handshakes with the L1 data cache so that dirty data is written back first. It also accepts coherence invalidates from the data cache.

## Interface
- `WAYS`, 4: associativity; a power of two, ≥ 2.
- `SETS`, 8: sets per way; a power of two, ≥ 2.
- `BLOCK_WORDS`, 4: 32-bit words per line; a power of two, ≥ 1.
- `ADDR_W`, 32: address width.
- Derived widths:
  - `OFF_W` = clog2(BLOCK_WORDS) + 2.
  - `SET_W` = clog2(SETS).
  - `TAG_W` = ADDR_W − SET_W − OFF_W.
  - `LINE_W` = 32·BLOCK_WORDS.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `cpu_valid_i` in 1: fetch request.
- `cpu_addr_i` in ADDR_W: fetch address; held stable until `cpu_ready_o`.
- `cpu_ready_o` out 1: `cpu_rdata_o` is valid this cycle.
- `cpu_rdata_o` out 32: fetched word.
- `inv_valid_i` in 1: invalidate request from the data cache.
- `inv_addr_i` in ADDR_W: address to invalidate.
- `flush_i` in 1: pulse; invalidates the whole cache.
- `flush_busy_o` out 1: a flush is in progress.
- `wb_req_o` out 1: asks the data cache to write back the line at `wb_addr_o`.
- `wb_addr_o` out ADDR_W: line-aligned miss address.
- `wb_done_i` in 1: data-cache write-back is complete.
- `mem_valid_o` out 1: line read request to memory.
- `mem_addr_o` out ADDR_W: line-aligned read address.
- `mem_ready_i` in 1: `mem_rdata_i` is valid.
- `mem_rdata_i` in LINE_W: refill line.

## Operation
- **Address split:** tag = `[ADDR_W-1 -: TAG_W]`, set = `[OFF_W +: SET_W]`, word = `[OFF_W-1:2]`.
- **Storage:** per way and set, one valid flop plus tag and data arrays. Valid flops and LRU state are reset; tag and data arrays are not.
- **State machine:** states are `LOOKUP`, `WB_WAIT`, `REFILL` and `FLUSH`.
- **`LOOKUP`:**
  - The tag compare across all ways is combinational.
  - On a hit, `cpu_ready_o` = 1 and the selected word is returned in the same cycle. The hit way is promoted to MRU at the clock edge.
  - On a miss with `cpu_valid_i`, go to `WB_WAIT`.
  - On `flush_i`, go to `FLUSH`. This takes priority over a CPU miss; a CPU hit in the same cycle is still served.
- **`WB_WAIT`:**
  - `wb_req_o` = 1 and `wb_addr_o` = line-aligned `cpu_addr_i`.
  - On `wb_done_i`, go to `REFILL`.
- **`REFILL`:**
  - `mem_valid_o` = 1 and `mem_addr_o` = line-aligned `cpu_addr_i`.
  - The victim is the first invalid way (lowest index), otherwise the LRU way. The victim is latched on entry to `REFILL`.
  - On `mem_ready_i`: write data and tag, set valid, promote the victim to MRU, and go to `LOOKUP`.
  - The request then hits in the following cycle.
- **`FLUSH`:**
  - A set counter runs 0..SETS−1 and clears the valid bits of all ways in one set per cycle.
  - After set SETS−1, go to `LOOKUP`.
  - `flush_busy_o` = 1 throughout. CPU and refill outputs stay 0.
  - `flush_i` while already in `FLUSH` is ignored.
- **Invalidates:**
  - Invalidates use an independent second tag compare on `inv_addr_i` and are serviced in every state.
  - A matching line's valid bit is cleared at the clock edge. LRU state is untouched.
  - If an invalidate hits the same set and tag in the cycle the CPU hits, the CPU still gets the (old) data.
- **Invalidate vs. refill:** if `inv_valid_i` matches the set and tag being refilled in the same cycle as `mem_ready_i`, the invalidate wins. The line is written with valid = 0, so the request misses again in `LOOKUP`.
- **LRU:**
  - Each set holds a clog2(WAYS)-bit age per way; 0 = MRU.
  - On promotion, ways younger than the promoted way age by +1, and the promoted way becomes 0.
  - Ages always form a permutation of 0..WAYS−1.
- **Other:** `cpu_valid_i` deasserting mid-miss does not abort the miss; the refill still completes.

## Timing
- **Reset values:** `cpu_ready_o`, `wb_req_o`, `mem_valid_o` and `flush_busy_o` = 0. `cpu_rdata_o`, `wb_addr_o` and `mem_addr_o` are 0 whenever their valid signal is 0.
- **Reset state:** state = `LOOKUP`, all valid = 0, way w has age w.
- **Hit latency:** 0 cycles (combinational ready).
- **Miss latency:** 1 (`WB_WAIT` entry) + write-back wait + memory wait + 1 (hit in `LOOKUP`).
- **Flush:** exactly SETS cycles of `flush_busy_o`.
- **Reset mid-operation:** reset in any state returns to the reset condition immediately. Outstanding `wb_req_o` and `mem_valid_o` drop asynchronously.
- **Handshake rule:** `wb_req_o` and `mem_valid_o` remain asserted, with stable addresses, until their respective done/ready inputs are sampled high.

## Structure
- `mem_pkg` holds:
  - the cache-entry typedef (valid, tag, data), parameterised via localparams;
  - the state enum;
  - the LRU age width helper.
- Sub-module `lru_ages`: a per-set age array with `promote_i`, `set_i` and `way_i` inputs and a `victim_o` output (oldest way). It is instantiated once and indexed by set.

## Test plan
- **Cold miss:** after reset, fetch 0x0000_0040.
  - Response: `wb_req_o` appears 1 cycle later. Drive `wb_done_i` → `mem_valid_o` with `mem_addr_o` = 0x40. Drive `mem_ready_i` with a line holding words A, B, C, D.
  - Required: the next cycle gives `cpu_ready_o` with A. Fetching 0x4C then hits with D in 0 cycles.
- **LRU eviction (WAYS = 4):**
  - Fill set 0 with tags T0..T3 in order, then hit T0.
  - Required: a miss on T4 evicts T1, and T0 still hits.
- **Invalidate:**
  - Set `inv_addr_i` to a resident line while in `LOOKUP`.
  - Required: the next fetch of that line misses. An invalidate to a non-resident address changes nothing.
- **Invalidate–refill collision:**
  - Assert `inv_valid_i` on the refill address in the same cycle as `mem_ready_i`.
  - Required: the FSM returns to `LOOKUP` and immediately re-enters `WB_WAIT`.
- **Flush:**
  - Pulse `flush_i` with SETS = 8.
  - Required: `flush_busy_o` stays high for 8 cycles, then all previously resident lines miss.
- **Asynchronous reset during `REFILL`:**
  - Required: `mem_valid_o` drops without a clock edge, and after release all fetches miss.
